// File: rtl/udp_payload_aligner.sv
// Strips HDR_BYTES of Eth/IPv4/UDP header and realigns the payload to byte 0; one registered output stage.
// Latency 1 cycle; s_axis_tready follows the output register's ability to drain and drops for the single FLUSH cycle.
module udp_payload_aligner #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_BYTES  = 42
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [15:0]           runt_drops
);

  localparam int R  = KEEP_WIDTH - HDR_BYTES;
  localparam int CW = $clog2(KEEP_WIDTH + 1);
  localparam logic [CW-1:0] HDR_K = CW'(HDR_BYTES);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [R*8-1:0]          residual;
  logic [R-1:0]            res_keep;
  logic                    err_acc, err_nxt;
  logic [CW-1:0]           k;
  logic [DATA_WIDTH-1:0]   masked;
  logic                    out_free, accept;
  logic                    out_load, res_load, runt_inc;
  logic [DATA_WIDTH-1:0]   out_dat;
  logic [KEEP_WIDTH-1:0]   out_keep;
  logic                    out_last, out_user;

  // Byte count and keep-masked data so bytes outside tkeep never reach the output.
  always_comb begin
    k      = '0;
    masked = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      k = k + CW'(s_axis_tkeep[i]);
      masked[i*8 +: 8] = s_axis_tdata[i*8 +: 8] & {8{s_axis_tkeep[i]}};
    end
  end

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && out_free && (state != FLUSH);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_nxt = state;
    out_load  = 1'b0;
    out_dat   = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    out_user  = 1'b0;
    res_load  = 1'b0;
    runt_inc  = 1'b0;
    err_nxt   = err_acc;
    case (state)
      IDLE: if (accept) begin
        if (!s_axis_tlast) begin
          res_load  = 1'b1;
          err_nxt   = s_axis_tuser;
          state_nxt = STREAM;
        end else if (k > HDR_K) begin
          out_load = 1'b1;
          out_dat  = masked >> (HDR_BYTES * 8);
          out_keep = s_axis_tkeep >> HDR_BYTES;
          out_last = 1'b1;
          out_user = s_axis_tuser;
          err_nxt  = 1'b0;
        end else begin
          runt_inc = 1'b1;
          err_nxt  = 1'b0;
        end
      end
      STREAM: if (accept) begin
        out_load = 1'b1;
        out_dat  = {masked[HDR_BYTES*8-1:0], residual};
        out_keep = '1;
        if (!s_axis_tlast) begin
          res_load = 1'b1;
          err_nxt  = err_acc | s_axis_tuser;
        end else if (k <= HDR_K) begin
          out_keep  = {s_axis_tkeep[HDR_BYTES-1:0], {R{1'b1}}};
          out_last  = 1'b1;
          out_user  = err_acc | s_axis_tuser;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          // Tail spills past this beat: the leftover goes out next cycle from the residual.
          res_load  = 1'b1;
          err_nxt   = err_acc | s_axis_tuser;
          state_nxt = FLUSH;
        end
      end
      FLUSH: if (out_free) begin
        out_load  = 1'b1;
        out_dat   = {{HDR_BYTES*8{1'b0}}, residual};
        out_keep  = {{HDR_BYTES{1'b0}}, res_keep};
        out_last  = 1'b1;
        out_user  = err_acc;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      residual      <= '0;
      res_keep      <= '0;
      err_acc       <= 1'b0;
      runt_drops    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_acc <= err_nxt;
      if (res_load) begin
        residual <= masked[DATA_WIDTH-1:HDR_BYTES*8];
        res_keep <= s_axis_tkeep[KEEP_WIDTH-1:HDR_BYTES];
      end
      if (runt_inc) runt_drops <= runt_drops + 16'd1;
      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= out_dat;
        m_axis_tkeep  <= out_keep;
        m_axis_tlast  <= out_last;
        m_axis_tuser  <= out_user;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_aligner.sv
// Bench for udp_payload_aligner: directed and random frames scored against a byte-queue payload model.
module tb_udp_payload_aligner;
  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int HDR = 42;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b1;
  logic [15:0]   runt_drops;

  always #5 aclk = ~aclk;

  udp_payload_aligner #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .HDR_BYTES(HDR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .runt_drops(runt_drops)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  beat_t        exp_q[$];
  byte unsigned fr_bytes[$];
  bit           fr_user[$];
  logic [15:0]  runt_exp = '0;
  int           stall_cnt = 0;
  int           rdy_mode = 0;
  bit           gaps = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: payload = frame bytes after the header, cut into KW-byte beats.
  task automatic model_frame();
    int n;
    bit u;
    n = fr_bytes.size() - HDR;
    u = 1'b0;
    foreach (fr_user[i]) u |= fr_user[i];
    if (n <= 0) runt_exp++;
    else begin
      for (int off = 0; off < n; off += KW) begin
        beat_t b;
        b.d = '0;
        b.k = '0;
        for (int j = 0; j < KW && off + j < n; j++) begin
          b.d[j*8 +: 8] = fr_bytes[HDR + off + j];
          b.k[j] = 1'b1;
        end
        b.l = (off + KW >= n);
        b.u = b.l ? u : 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic make_frame(input int len, input int ub, input bit seq);
    fr_bytes.delete();
    fr_user.delete();
    for (int i = 0; i < len; i++) fr_bytes.push_back(seq ? 8'(i) : 8'($urandom));
    for (int b = 0; b < (len + KW - 1) / KW; b++) fr_user.push_back(b == ub);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
    int w;
    w = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    while (1) begin
      @(negedge aclk);
      if (s_tready) break;
      stall_cnt++;
      w++;
      if (w > 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_axis_tready observed 0 for %0d cycles, expected 1 within 2000", w);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "stalled input");
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame();
    int n, nb, idx;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    n  = fr_bytes.size();
    nb = (n + KW - 1) / KW;
    model_frame();
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < KW; j++) begin
        idx = b * KW + j;
        d[j*8 +: 8] = (idx < n) ? fr_bytes[idx] : 8'($urandom);
        k[j] = (idx < n);
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      send_beat(d, k, b == nb - 1, fr_user[b]);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_tvalid) && w < 5000) begin
      @(posedge aclk);
      w++;
    end
    #1;
    chk("drain_pending", DW'(exp_q.size()), DW'(0));
  endtask

  // Downstream ready pattern: 0 always, 1 toggling, 2 random.
  initial forever begin
    @(posedge aclk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output scoreboard plus stall-stability check.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [KW+1:0] prev_ctl;
  always @(negedge aclk) begin
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_data", m_tdata, prev_d);
        chk("hold_ctl", DW'({m_tkeep, m_tlast, m_tuser}), DW'(prev_ctl));
      end
      if (m_tvalid && m_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_beat: observed output beat keep=%0h, expected no beat", m_tkeep);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", DW'(m_tkeep), DW'(e.k));
          chk("out_last", DW'(m_tlast), DW'(e.l));
          chk("out_user", DW'(m_tuser), DW'(e.u));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_ctl   = {m_tkeep, m_tlast, m_tuser};
    end
  end

  initial begin
    logic [KW-1:0] k42;
    int            n_wrap;
    // Reset state, with an input already presented.
    s_tvalid = 1'b1; s_tkeep = '1; s_tlast = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", DW'(s_tready), DW'(0));
    chk("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_m_tdata", m_tdata, DW'(0));
    chk("rst_m_tkeep", DW'(m_tkeep), DW'(0));
    chk("rst_m_tlast_tuser", DW'({m_tlast, m_tuser}), DW'(0));
    chk("rst_runt", DW'(runt_drops), DW'(0));
    s_tvalid = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single full beat: 22 payload bytes, one cycle after acceptance.
    make_frame(64, -1, 1'b1); send_frame();
    chk("single_lat_vld", DW'(m_tvalid), DW'(1));
    chk("single_keep", DW'(m_tkeep), DW'(64'h3FFFFF));
    wait_drain();

    // 64 + 30: merged into one 52-byte last beat.
    make_frame(94, -1, 1'b1); send_frame();
    chk("merge_keep", DW'(m_tkeep), DW'(64'h000F_FFFF_FFFF_FFFF));
    chk("merge_last", DW'(m_tlast), DW'(1));
    wait_drain();

    // 64 + 50: full beat then an 8-byte flush beat, input held off meanwhile.
    make_frame(114, -1, 1'b1); send_frame();
    chk("flush_tready", DW'(s_tready), DW'(0));
    chk("flush_first_last", DW'(m_tlast), DW'(0));
    @(posedge aclk); #1;
    chk("flush_keep", DW'(m_tkeep), DW'(64'hFF));
    chk("flush_last", DW'(m_tlast), DW'(1));
    wait_drain();

    // Runts: header-only and shorter-than-header frames.
    make_frame(42, -1, 1'b0); send_frame();
    chk("runt_one", DW'(runt_drops), DW'(runt_exp));
    make_frame(10, 0, 1'b0); send_frame();
    chk("runt_two", DW'(runt_drops), DW'(runt_exp));
    wait_drain();
    n_wrap = 65536 - int'(runt_exp);
    k42 = '0;
    for (int i = 0; i < HDR; i++) k42[i] = 1'b1;
    s_tdata = {16{32'($urandom)}}; s_tkeep = k42; s_tlast = 1'b1; s_tuser = 1'b0; s_tvalid = 1'b1;
    repeat (n_wrap) @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    runt_exp = runt_exp + 16'(n_wrap);
    chk("runt_wrap", DW'(runt_drops), DW'(runt_exp));
    chk("runt_wrap_no_out", DW'(m_tvalid), DW'(0));

    // Back-to-back beats with a free output never stall.
    stall_cnt = 0;
    make_frame(148, -1, 1'b0); send_frame();
    chk("no_bubble", DW'(stall_cnt), DW'(0));
    wait_drain();

    // Three-beat frames, tuser on beat 2, toggling downstream ready.
    rdy_mode = 1;
    make_frame(150, 1, 1'b0); send_frame();
    make_frame(180, 1, 1'b0); send_frame();
    wait_drain();

    // Random lengths, errors, gaps and backpressure.
    rdy_mode = 2;
    gaps = 1'b1;
    repeat (40) begin
      make_frame($urandom_range(1, 300), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, 1'b0);
      send_frame();
    end
    wait_drain();

    // Reset mid-frame discards it; the next frame starts clean.
    rdy_mode = 0;
    gaps = 1'b0;
    @(posedge aclk); #1;
    make_frame(10, -1, 1'b0); send_frame();
    send_beat({16{32'($urandom)}}, '1, 1'b0, 1'b1);
    aresetn = 1'b0;
    #1;
    runt_exp = '0;
    chk("mid_rst_tready", DW'(s_tready), DW'(0));
    chk("mid_rst_vld_last_user", DW'({m_tvalid, m_tlast, m_tuser}), DW'(0));
    chk("mid_rst_data", m_tdata, DW'(0));
    chk("mid_rst_keep", DW'(m_tkeep), DW'(0));
    chk("mid_rst_runt", DW'(runt_drops), DW'(0));
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    make_frame(64, -1, 1'b1); send_frame();
    chk("post_rst_keep", DW'(m_tkeep), DW'(64'h3FFFFF));
    chk("post_rst_user", DW'(m_tuser), DW'(0));
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
